// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and its sequencer.
// Provides the fetch sequencer state encoding, the default reset PC and the
// default instruction RAM word-address width (shared with the RAM depth).
package cpu_pkg;

    // Instruction RAM word-address width; RAM depth is 2**CPU_ADDR_W words.
    localparam int unsigned CPU_ADDR_W = 3;

    // PC after reset and after a completed program load.
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_LOAD   = 2'd1,
        S_RESUME = 2'd2
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer.
// Owns the architectural PC, picks the next PC (fetch-stage PC+4, branch/jump
// redirect or stall hold) and time-shares the instruction RAM port between
// normal fetch and a word-serial program loader.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   stall, redirect          hazard hold / taken branch request
//   redirect_pc              branch/jump target (byte address, word-aligned here)
//   npc                      PC+4 computed by the fetch stage
//   ld_req/ld_addr/ld_data   loader word handshake, word address and data
//   ld_last                  marks the final loader word
//   ld_ack                   loader word written this cycle (combinational)
//   pc                       fetch-stage / RAM byte address
//   ram_ena/ram_wena         RAM enable / write enable
//   ram_indata               RAM write data
//   if_valid                 current fetch is a real instruction
//   ld_count                 words written in the current or latest load
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = CPU_ADDR_W,
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic [31:0]       npc,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ack,
    output logic [31:0]       pc,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [31:0]       ram_indata,
    output logic              if_valid,
    output logic [ADDR_W:0]   ld_count
);

    localparam int unsigned          CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(1) << ADDR_W;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      redirect_tgt;
    logic [31:0]      ld_pc;
    logic             unused_rpc_lsb;

    // Targets are forced onto a word boundary; the byte-offset bits are dropped.
    assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // Loader word address expressed as a RAM byte address.
    assign ld_pc = 32'({ld_addr, 2'b00});

    // Write data is only meaningful while ram_wena is high.
    assign ram_indata = ld_data;
    assign ld_count   = cnt_q;

    // State, PC and load counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next-PC and RAM port control.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        pc       = pc_q;
        ram_ena  = 1'b0;
        ram_wena = 1'b0;
        ld_ack   = 1'b0;
        if_valid = 1'b0;

        case (state_q)
            S_RUN: begin
                ram_ena  = 1'b1;
                if_valid = !stall && !redirect;
                // A redirect wins over a load request; the load is taken on a
                // later cycle if ld_req is still held.
                if (redirect) begin
                    pc_d = redirect_tgt;
                end else if (ld_req) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else if (!stall) begin
                    pc_d = npc;
                end
            end

            S_LOAD: begin
                pc = ld_pc;
                if (ld_req) begin
                    ram_ena  = 1'b1;
                    ram_wena = 1'b1;
                    ld_ack   = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (ld_last) begin
                        pc_d    = RESET_PC;
                        state_d = S_RESUME;
                    end
                end
            end

            // One read-latency bubble before fetching from the reset PC.
            S_RESUME: begin
                pc      = RESET_PC;
                ram_ena = 1'b1;
                state_d = S_RUN;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase

        // Outputs are held quiet for the whole time reset is asserted.
        if (rst) begin
            pc       = RESET_PC;
            ram_ena  = 1'b0;
            ram_wena = 1'b0;
            ld_ack   = 1'b0;
            if_valid = 1'b0;
        end
    end

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: models the fetch stage (PC+4 and the
// instruction RAM) and compares per-cycle outputs through a scoreboard queue.
module tb_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic        ena;
        logic        wena;
        logic        ack;
        logic        ifv;
        logic [3:0]  cnt;
        logic [31:0] wd;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] npc;
    logic        ld_req;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ack;
    logic [31:0] pc;
    logic        ram_ena;
    logic        ram_wena;
    logic [31:0] ram_indata;
    logic        if_valid;
    logic [3:0]  ld_count;

    logic [31:0] mem [8];

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   n_vec;
    int   n_err;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .npc         (npc),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ack      (ld_ack),
        .pc          (pc),
        .ram_ena     (ram_ena),
        .ram_wena    (ram_wena),
        .ram_indata  (ram_indata),
        .if_valid    (if_valid),
        .ld_count    (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch-stage model: PC+4 adder and the instruction RAM write port.
    assign npc = pc + 32'd4;
    always @(posedge clk) begin
        if (ram_ena && ram_wena) mem[pc[4:2]] <= ram_indata;
    end

    function automatic obs_t sample();
        return obs_t'{pc, ram_ena, ram_wena, ld_ack, if_valid, ld_count, ram_indata};
    endfunction

    function automatic string fmt(obs_t x);
        return $sformatf("pc=%h ena=%b wena=%b ack=%b ifv=%b cnt=%0d wdata=%h",
                         x.pc, x.ena, x.wena, x.ack, x.ifv, x.cnt, x.wd);
    endfunction

    // One cycle starting at a falling edge: drive, record expected, sample.
    // e_f = {ram_ena, ram_wena, ld_ack, if_valid}
    task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                        input logic req, input logic [2:0] a, input logic [31:0] d,
                        input logic last, input logic [31:0] e_pc,
                        input logic [3:0] e_f, input logic [3:0] e_cnt);
        stall = s; redirect = r; redirect_pc = rpc;
        ld_req = req; ld_addr = a; ld_data = d; ld_last = last;
        exp_q.push_back(obs_t'{e_pc, e_f[3], e_f[2], e_f[1], e_f[0], e_cnt, d});
        #1;
        obs_q.push_back(sample());
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        ld_req = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        idle_inputs();
        rst = 1'b1;
        #1;
        o = sample();
        e = obs_t'{32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset: got %s exp %s", fmt(o), fmt(e)); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        obs_t o, e;
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b1001, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h4, 4'b1001, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h8, 4'b1001, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'hC, 4'b1001, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL free_run[%0d]: got %s exp %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_stall();
        obs_t o, e;
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b1001, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h4, 4'b1001, 0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h8, 4'b1000, 0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h8, 4'b1000, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h8, 4'b1001, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'hC, 4'b1001, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL stall[%0d]: got %s exp %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_redirect();
        obs_t o, e;
        do_reset();
        step(1, 1, 32'h13, 0, 0, 0, 0, 32'h0,  4'b1000, 0);
        step(0, 0, 0,      0, 0, 0, 0, 32'h10, 4'b1001, 0);
        step(0, 0, 0,      0, 0, 0, 0, 32'h14, 4'b1001, 0);
        step(0, 1, 32'h3F, 0, 0, 0, 0, 32'h18, 4'b1000, 0);
        step(0, 0, 0,      0, 0, 0, 0, 32'h3C, 4'b1001, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL redirect[%0d]: got %s exp %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_load();
        obs_t o, e;
        do_reset();
        step(0, 0, 0,      1, 3'd2, 32'hD0, 0, 32'h0,  4'b1001, 0);
        step(0, 0, 0,      1, 3'd2, 32'hD0, 0, 32'h8,  4'b1110, 0);
        step(1, 1, 32'h40, 0, 3'd0, 32'h0,  0, 32'h0,  4'b0000, 1);
        step(0, 0, 0,      1, 3'd5, 32'hD1, 0, 32'h14, 4'b1110, 1);
        step(0, 0, 0,      1, 3'd7, 32'hD2, 1, 32'h1C, 4'b1110, 2);
        step(0, 0, 0,      0, 3'd0, 32'h0,  0, 32'h0,  4'b1000, 3);
        step(0, 0, 0,      0, 3'd0, 32'h0,  0, 32'h0,  4'b1001, 3);
        step(0, 0, 0,      0, 3'd0, 32'h0,  0, 32'h4,  4'b1001, 3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL load[%0d]: got %s exp %s", i, fmt(o), fmt(e)); end
        end
        n_vec++;
        if (mem[2] !== 32'hD0) begin n_err++; $display("FAIL load_mem2: got %h exp %h", mem[2], 32'hD0); end
        n_vec++;
        if (mem[5] !== 32'hD1) begin n_err++; $display("FAIL load_mem5: got %h exp %h", mem[5], 32'hD1); end
        n_vec++;
        if (mem[7] !== 32'hD2) begin n_err++; $display("FAIL load_mem7: got %h exp %h", mem[7], 32'hD2); end
    endtask

    task automatic test_saturate();
        obs_t o, e;
        do_reset();
        step(0, 0, 0, 1, 3'd0, 32'hA0, 0, 32'h0, 4'b1001, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 3'(i), 32'hA0 + 32'(i), (i == 8),
                 {27'd0, 3'(i), 2'b00}, 4'b1110, 4'(i));
        end
        step(0, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0, 4'b1000, 8);
        step(0, 0, 0, 0, 3'd0, 32'h0, 0, 32'h0, 4'b1001, 8);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL saturate[%0d]: got %s exp %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_redirect_load();
        obs_t o, e;
        do_reset();
        step(0, 1, 32'h20, 1, 3'd1, 32'hE0, 0, 32'h0,  4'b1000, 0);
        step(0, 0, 0,      1, 3'd1, 32'hE0, 0, 32'h20, 4'b1001, 0);
        step(0, 0, 0,      1, 3'd1, 32'hE0, 0, 32'h4,  4'b1110, 0);
        step(0, 0, 0,      1, 3'd3, 32'hE1, 0, 32'hC,  4'b1110, 1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL redirect_load[%0d]: got %s exp %s", i, fmt(o), fmt(e)); end
        end
    endtask

    // Continues from the open load left by test_redirect_load (2 words written).
    task automatic test_reset_mid_load();
        obs_t o, e;
        stall = 1'b0; redirect = 1'b0;
        ld_req = 1'b1; ld_addr = 3'd6; ld_data = 32'hE2; ld_last = 1'b0;
        #1;
        o = sample();
        e = obs_t'{32'h18, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 32'hE2};
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL mid_load_pre: got %s exp %s", fmt(o), fmt(e)); end
        #1 rst = 1'b1;
        #1;
        o = sample();
        e = obs_t'{32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'hE2};
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL mid_load_async: got %s exp %s", fmt(o), fmt(e)); end
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b1001, 0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h4, 4'b1001, 0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL mid_load_post[%0d]: got %s exp %s", i, fmt(o), fmt(e)); end
        end
        n_vec++;
        if (mem[1] !== 32'hE0) begin n_err++; $display("FAIL mid_load_mem1: got %h exp %h", mem[1], 32'hE0); end
        n_vec++;
        if (mem[3] !== 32'hE1) begin n_err++; $display("FAIL mid_load_mem3: got %h exp %h", mem[3], 32'hE1); end
        n_vec++;
        if (mem[6] !== 32'hA6) begin n_err++; $display("FAIL mid_load_mem6: got %h exp %h", mem[6], 32'hA6); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_load();
        test_saturate();
        test_redirect_load();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage. Owns the architectural PC register, selects the next PC from the fetch-stage PC+4, a branch/jump redirect or a stall hold, and shares the instruction RAM port between normal fetch and a word-serial program loader. Sits between the hazard/branch logic and the fetch stage. Drives that stage's `pc`, `ram_ena`, `ram_wena` and `ram_indata` inputs and consumes its `npc` output.

## Interface
Parameters:
- `ADDR_W`, 3: instruction RAM word-address width; the RAM address is `pc[ADDR_W+1:2]`.
- `RESET_PC`, 32'h0000_0000: PC value after reset and after a completed load.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard unit request to hold the PC.
- `redirect` in 1: branch/jump taken.
- `redirect_pc` in 32: target for `redirect`.
- `npc` in 32: PC+4 from the fetch stage.
- `ld_req` in 1: loader has a word valid.
- `ld_addr` in ADDR_W: loader word address.
- `ld_data` in 32: loader instruction word.
- `ld_last` in 1: qualifies the final word of the load.
- `ld_ack` out 1: word accepted and written this cycle.
- `pc` out 32: fetch-stage address.
- `ram_ena` out 1: RAM enable.
- `ram_wena` out 1: RAM write enable.
- `ram_indata` out 32: RAM write data.
- `if_valid` out 1: the current fetch is a real instruction, not a bubble.
- `ld_count` out ADDR_W+1: number of words written in the current or most recent load.

## Operation
States: RUN, LOAD, RESUME.

RUN:
- `pc` output equals `pc_q`.
- `ram_ena`=1, `ram_wena`=0.
- `if_valid` = !stall && !redirect.
- Next `pc_q`, in priority order:
  - `redirect` gives `{redirect_pc[31:2],2'b00}`.
  - Otherwise `stall` holds.
  - Otherwise `npc`.
- `ld_req`=1 with `redirect`=0 sets next state to LOAD, holds `pc_q` and clears `ld_count`.
- `ld_req` and `redirect` in the same cycle: the redirect is applied first, and LOAD is entered on the next cycle if `ld_req` is still high.

LOAD:
- `pc` output = `{zeros, ld_addr, 2'b00}`.
- `ram_indata` = `ld_data`.
- `if_valid`=0.
- `stall` and `redirect` are ignored.
- With `ld_req`=1:
  - `ram_ena`=`ram_wena`=`ld_ack`=1 (combinational).
  - `ld_count` increments.
  - If `ld_last`=1: `pc_q`<=RESET_PC and next state is RESUME.
- With `ld_req`=0: `ram_ena`=`ram_wena`=`ld_ack`=0 and the block stays in LOAD.
- `ld_count` saturates at 2^ADDR_W.
- Repeated `ld_addr` values overwrite; no check is made.

RESUME:
- Lasts exactly one cycle.
- `pc`=RESET_PC, `ram_ena`=1, `ram_wena`=0, `if_valid`=0. This is the RAM read-latency bubble.
- `pc_q` holds. Next state is RUN.
- `ld_req` is not acknowledged in this state.

Arithmetic:
- `npc` wraps modulo 2^32 with no detection.
- `ram_indata` is don't-care (driven as `ld_data`) whenever `ram_wena`=0.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - State RUN, `pc_q`=RESET_PC, `ld_count`=0.
  - While `rst`=1: `ram_ena`=`ram_wena`=`ld_ack`=`if_valid`=0 and `pc`=RESET_PC.
- PC update latency is 1 cycle: a redirect in cycle N makes `pc`=target in N+1.
- Load entry: `ld_req` rising in RUN at cycle N gives the first `ld_ack` at N+1 at the earliest.
- Load exit: `ld_last` acknowledged at N gives RESUME at N+1 and RUN with `pc`=RESET_PC at N+2, where `if_valid`=1 unless stalled.
- Reset mid-load: the load is aborted, `ld_count`=0, and RAM contents are left partial.

## Structure
- Shared package `cpu_pkg`:
  - State encodings S_RUN=2'd0, S_LOAD=2'd1, S_RESUME=2'd2.
  - Default RESET_PC.
  - ADDR_W default, shared with the fetch stage's RAM depth.
- No sub-module: a next-PC mux, a state register and a counter in one module.
- The PC+4 adder stays in the fetch stage and is not duplicated here.

## Test plan
- Reset then free run, `npc`=`pc`+4 modelled: `pc` sequence 0,4,8,C; `if_valid`=1 from the first cycle after reset release.
- `stall` for 2 cycles at `pc`=8: `pc` stays 8 for 2 cycles with `if_valid`=0, then 0xC.
- `redirect` with `redirect_pc`=0x13 concurrent with `stall`: next `pc`=0x10; the stall is overridden.
- Load 3 words at addresses 2,5,7 with a 1-cycle `ld_req` gap, last on 7: `ld_ack` on 3 cycles; writes go to `pc`=0x8,0x14,0x1C with `ram_wena`=1; `ld_count`=3; one RESUME cycle with `if_valid`=0; then RUN at `pc`=0.
- `ld_req` and `redirect` (target 0x20) in the same cycle: `pc`=0x20 next cycle, then LOAD; the first `ld_ack` arrives one cycle later.
- `rst` asserted mid-load after 2 words: all outputs go to reset values asynchronously; after release the state is RUN, `pc`=0, `ld_count`=0.
